// File: rtl/eth_tx_arbiter.sv
// Ethernet TX arbiter: grants one packet source at a time onto the shared Avalon-ST TX port,
// muxes the selected source's beats and drops stray beats. Define ARB_WATCHDOG_EN to add a grant watchdog.

module eth_tx_arbiter #(
  parameter int unsigned REQ_NUM       = 4,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter logic [15:0] MAX_GRANT_CYC = 16'd4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [2*REQ_NUM-1:0]          req_level,
  input  logic [REQ_NUM-1:0]            req_eop,
  output logic [REQ_NUM-1:0]            grant,
  output logic                          src_ready,
  input  logic [REQ_NUM-1:0]            src_valid,
  input  logic [REQ_NUM-1:0]            src_sop,
  input  logic [REQ_NUM-1:0]            src_eop,
  input  logic [REQ_NUM-1:0]            src_error,
  input  logic [DATA_WIDTH*REQ_NUM-1:0] src_data,
  input  logic [3*REQ_NUM-1:0]          src_empty,
  input  logic                          dout_ready,
  output logic                          dout_valid,
  output logic                          dout_sop,
  output logic                          dout_eop,
  output logic                          dout_error,
  output logic [DATA_WIDTH-1:0]         dout_data,
  output logic [2:0]                    dout_empty,
  output logic [2:0]                    owner,
  output logic                          busy,
  output logic [15:0]                   drop_cnt,
  output logic                          stray_err,
  output logic                          wdog_err
);

  localparam int unsigned IDX_W = 3;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  if (REQ_NUM < 2 || REQ_NUM > 8 || MAX_GRANT_CYC == 16'd0) begin : g_bad_cfg
    $error("eth_tx_arbiter: unsupported parameter configuration");
  end

  state_e                 state_q, state_d;
  logic [REQ_NUM-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       data_sel_q, data_sel_d;
  logic                   in_pkt_q, in_pkt_d;
  logic                   dout_valid_q, dout_valid_d;
  logic                   dout_sop_q, dout_sop_d;
  logic                   dout_eop_q, dout_eop_d;
  logic                   dout_error_q, dout_error_d;
  logic [DATA_WIDTH-1:0]  dout_data_q, dout_data_d;
  logic [2:0]             dout_empty_q, dout_empty_d;
  logic [15:0]            drop_cnt_q, drop_cnt_d;
  logic                   stray_err_q, stray_err_d;

  logic                   arb_valid;
  logic [IDX_W-1:0]       arb_winner;
  logic                   urg_found, nrm_found;
  logic [IDX_W-1:0]       urg_idx, nrm_idx;
  int unsigned            arb_pos;
  logic                   owner_eop;
  logic                   release_grant;
  logic                   award;
  logic                   wdog_hit;
  logic                   sel_valid, sel_sop, sel_eop, sel_error;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic [2:0]             sel_empty;
  logic                   accept;
  logic                   stray;

  // Urgent-first, then round-robin from rr_ptr+1 within each level.
  always_comb begin
    urg_found = 1'b0;
    nrm_found = 1'b0;
    urg_idx   = '0;
    nrm_idx   = '0;
    arb_pos   = 0;
    for (int unsigned k = 1; k <= REQ_NUM; k++) begin
      arb_pos = 32'(rr_ptr_q) + k;
      if (arb_pos >= REQ_NUM) arb_pos = arb_pos - REQ_NUM;
      for (int unsigned i = 0; i < REQ_NUM; i++) begin
        if (arb_pos == i) begin
          if (req_level[2*i +: 2] == 2'd3 && !urg_found) begin
            urg_found = 1'b1;
            urg_idx   = IDX_W'(i);
          end
          if (req_level[2*i +: 2] != 2'd0 && !nrm_found) begin
            nrm_found = 1'b1;
            nrm_idx   = IDX_W'(i);
          end
        end
      end
    end
    arb_valid  = nrm_found;
    arb_winner = urg_found ? urg_idx : nrm_idx;
  end

  // Grant FSM: hold the grant for one packet, re-arbitrate on the owner's arbitration-EOP.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    award     = 1'b0;
    owner_eop = 1'b0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      if (owner_q == IDX_W'(i)) owner_eop = req_eop[i];
    end
    release_grant = (state_q == GRANT) && (owner_eop || wdog_hit);
    if (state_q == IDLE || release_grant) begin
      if (arb_valid) begin
        award    = 1'b1;
        state_d  = GRANT;
        owner_d  = arb_winner;
        rr_ptr_d = arb_winner;
        for (int unsigned i = 0; i < REQ_NUM; i++) begin
          grant_d[i] = (arb_winner == IDX_W'(i));
        end
      end else begin
        state_d = IDLE;
        grant_d = '0;
      end
    end
  end

  // Data path: selected source mux, packet tracking and stray-beat policing.
  always_comb begin
    sel_valid = 1'b0;
    sel_sop   = 1'b0;
    sel_eop   = 1'b0;
    sel_error = 1'b0;
    sel_data  = '0;
    sel_empty = '0;
    stray     = 1'b0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      if (data_sel_q == IDX_W'(i)) begin
        sel_valid = src_valid[i];
        sel_sop   = src_sop[i];
        sel_eop   = src_eop[i];
        sel_error = src_error[i];
        sel_data  = src_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_empty = src_empty[3*i +: 3];
      end else if (src_valid[i]) begin
        stray = 1'b1;
      end
    end

    accept   = sel_valid && dout_ready;
    in_pkt_d = in_pkt_q;
    if (accept && sel_sop) in_pkt_d = 1'b1;
    if (accept && sel_eop) in_pkt_d = 1'b0;
    if (wdog_hit)          in_pkt_d = 1'b0;
    data_sel_d = in_pkt_q ? data_sel_q : owner_q;

    dout_valid_d = dout_valid_q;
    dout_sop_d   = dout_sop_q;
    dout_eop_d   = dout_eop_q;
    dout_error_d = dout_error_q;
    dout_data_d  = dout_data_q;
    dout_empty_d = dout_empty_q;
    if (dout_ready) begin
      dout_valid_d = sel_valid;
      dout_sop_d   = sel_valid && sel_sop;
      dout_eop_d   = sel_valid && sel_eop;
      dout_error_d = sel_valid && sel_error;
      dout_data_d  = sel_data;
      dout_empty_d = sel_empty;
    end

    drop_cnt_d  = drop_cnt_q;
    stray_err_d = stray_err_q || stray;
    if (stray && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      data_sel_q   <= '0;
      in_pkt_q     <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_sop_q   <= 1'b0;
      dout_eop_q   <= 1'b0;
      dout_error_q <= 1'b0;
      dout_data_q  <= '0;
      dout_empty_q <= '0;
      drop_cnt_q   <= '0;
      stray_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      data_sel_q   <= data_sel_d;
      in_pkt_q     <= in_pkt_d;
      dout_valid_q <= dout_valid_d;
      dout_sop_q   <= dout_sop_d;
      dout_eop_q   <= dout_eop_d;
      dout_error_q <= dout_error_d;
      dout_data_q  <= dout_data_d;
      dout_empty_q <= dout_empty_d;
      drop_cnt_q   <= drop_cnt_d;
      stray_err_q  <= stray_err_d;
    end
  end

`ifdef ARB_WATCHDOG_EN
  logic [15:0] wdog_cnt_q, wdog_cnt_d;
  logic        wdog_err_q, wdog_err_d;

  // Owner that never signals its arbitration-EOP is released after MAX_GRANT_CYC cycles.
  assign wdog_hit = (state_q == GRANT) && !owner_eop && (wdog_cnt_q == MAX_GRANT_CYC - 16'd1);

  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    if (award)                 wdog_cnt_d = '0;
    else if (state_q == GRANT) wdog_cnt_d = wdog_cnt_q + 16'd1;
    wdog_err_d = wdog_err_q || wdog_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  assign wdog_hit = 1'b0;
  assign wdog_err = 1'b0;
`endif

  assign src_ready  = dout_ready && !rst;
  assign grant      = grant_q;
  assign owner      = owner_q;
  assign busy       = (state_q == GRANT);
  assign dout_valid = dout_valid_q;
  assign dout_sop   = dout_sop_q;
  assign dout_eop   = dout_eop_q;
  assign dout_error = dout_error_q;
  assign dout_data  = dout_data_q;
  assign dout_empty = dout_empty_q;
  assign drop_cnt   = drop_cnt_q;
  assign stray_err  = stray_err_q;

endmodule
